alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, datapath width in bits.
REQ-002 SHALL have parameter PC_INC, default 4, sequential PC increment.
REQ-003 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1, operands and controls valid this cycle.
REQ-006 SHALL have port alu_op_1, input, 1, ALUOp high bit.
REQ-007 SHALL have port alu_op_0, input, 1, ALUOp low bit.
REQ-008 SHALL have port instruction_part, input, 11, instruction bits [31:21].
REQ-009 SHALL have port input_data_1, input, WIDTH, operand A.
REQ-010 SHALL have port input_data_2, input, WIDTH, operand B.
REQ-011 SHALL have port pc, input, WIDTH, current instruction address.
REQ-012 SHALL have port offset, input, WIDTH, sign-extended branch offset in words.
REQ-013 SHALL have port out_valid, output, 1, results valid.
REQ-014 SHALL have port operation_code, output, 4, decoded ALU operation.
REQ-015 SHALL have port output_data, output, WIDTH, ALU result.
REQ-016 SHALL have port output_zero, output, 1, result equals zero.
REQ-017 SHALL have port output_illegal, output, 1, unknown R-type opcode.
REQ-018 SHALL have port output_pc_next, output, WIDTH, pc + PC_INC.
REQ-019 SHALL have port output_branch_target, output, WIDTH, pc + (offset << 2).

Function
REQ-020 SHALL decode {alu_op_1,alu_op_0}: 00 -> 0010 (add); 01 -> 0111 (pass B); 1x -> R-type decode of instruction_part.
REQ-021 R-type decode SHALL be: 10001011000 -> 0010 ADD; 11001011000 -> 0110 SUB; 10001010000 -> 0000 AND; 10101010000 -> 0001 ORR; any other -> 1111 with output_illegal=1.
REQ-022 SHALL compute: 0000 A&B; 0001 A|B; 0010 A+B; 0110 A-B; 0111 B; 1100 ~(A|B); any other code -> 0.
REQ-023 Add/sub SHALL be modulo 2^WIDTH, carry and borrow discarded.
REQ-024 output_zero SHALL be 1 iff the registered output_data is all zeros.
REQ-025 Adders SHALL be modulo 2^WIDTH; branch target uses offset shifted left 2, upper bits discarded.
REQ-026 All outputs SHALL be registered; latency exactly 1 cycle from in_valid to out_valid.
REQ-027 On a cycle with in_valid=1, all result registers SHALL load; with in_valid=0 they SHALL hold and out_valid SHALL be 0 next cycle.
REQ-028 Back-to-back in_valid SHALL give one result per cycle, no bubbles.
REQ-029 output_illegal SHALL be 0 whenever ALUOp is 00 or 01.

Reset
REQ-030 While reset=1, all outputs SHALL be 0 immediately (asynchronous), including output_zero and out_valid.
REQ-031 An operation accepted in the cycle reset asserts SHALL be discarded; first valid result follows the first in_valid after reset release.

Configuration
REQ-032 With macro ALU_EXEC_FLAGS_EN defined, SHALL add registered 1-bit outputs output_negative (result MSB), output_carry (add/sub carry-out, sub as A+~B+1) and output_overflow (signed overflow), reset to 0, 0 for logic ops.
REQ-033 Without ALU_EXEC_FLAGS_EN, these ports and their logic SHALL be absent; other behaviour is unchanged.

Structure
REQ-034 Package alu_exec_pkg SHALL hold the 4-bit operation-code constants, the four 11-bit R-type opcode constants and the ALUOp encodings.
REQ-035 Decode SHALL be one combinational sub-module alu_exec_decode (ALUOp, instruction_part -> operation_code, illegal); ALU and adders are inline.

Verification
REQ-036 ALUOp=00, A=10, B=32, pc=0x100, offset=3 -> next cycle output_data=42, output_zero=0, output_pc_next=0x104, output_branch_target=0x10C.
REQ-037 ALUOp=10, opcode 11001011000, A=5, B=5 -> operation_code=0110, output_data=0, output_zero=1.
REQ-038 ALUOp=01, A=7, B=0 -> output_data=0, output_zero=1 (CBZ taken); with B=9 -> output_data=9, output_zero=0.
REQ-039 ALUOp=10, opcode 10101010000, A=0xF0, B=0x0F -> output_data=0xFF; opcode 11111111111 -> output_illegal=1, output_data=0, operation_code=1111.
REQ-040 Adder wrap: ALUOp=00, A=0xFFFF_FFFF_FFFF_FFFF, B=1 -> output_data=0, output_zero=1; pc=0x8, offset=-4 -> output_branch_target=0xFFFF_FFFF_FFFF_FFF8.
REQ-041 Assert reset mid-stream with in_valid=1 -> all outputs 0 without a clock edge; no out_valid until a new in_valid after release.

Source files
------------

// File: rtl/alu_exec_pkg.sv
// rtl/alu_exec_pkg.sv - operation codes, R-type opcodes and ALUOp encodings for alu_exec_unit
package alu_exec_pkg;

    // 4-bit operation codes presented on operation_code
    localparam logic [3:0] OP_AND     = 4'b0000;
    localparam logic [3:0] OP_ORR     = 4'b0001;
    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_PASS_B  = 4'b0111;
    localparam logic [3:0] OP_NOR     = 4'b1100;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    // R-type opcodes, instruction bits [31:21]
    localparam logic [10:0] RTYPE_ADD = 11'b10001011000;
    localparam logic [10:0] RTYPE_SUB = 11'b11001011000;
    localparam logic [10:0] RTYPE_AND = 11'b10001010000;
    localparam logic [10:0] RTYPE_ORR = 11'b10101010000;

    // ALUOp encodings; any value with the high bit set selects R-type decode
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_PASS_B = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE  = 2'b10;

endpackage

// File: rtl/alu_exec_decode.sv
// rtl/alu_exec_decode.sv - combinational ALU control decode
// Ports: alu_op_1/alu_op_0 (ALUOp), instruction_part (instr[31:21])
//        -> operation_code (4-bit ALU op), illegal (unknown R-type opcode)
module alu_exec_decode
    import alu_exec_pkg::*;
(
    input  logic        alu_op_1,
    input  logic        alu_op_0,
    input  logic [10:0] instruction_part,
    output logic [3:0]  operation_code,
    output logic        illegal
);

    always_comb begin
        operation_code = OP_ADD;
        illegal        = 1'b0;
        if (alu_op_1) begin
            // alu_op_0 is a don't-care once the high bit selects R-type
            case (instruction_part)
                RTYPE_ADD: operation_code = OP_ADD;
                RTYPE_SUB: operation_code = OP_SUB;
                RTYPE_AND: operation_code = OP_AND;
                RTYPE_ORR: operation_code = OP_ORR;
                default: begin
                    operation_code = OP_ILLEGAL;
                    illegal        = 1'b1;
                end
            endcase
        end else if (alu_op_0) begin
            operation_code = OP_PASS_B;
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - single-cycle-latency registered ALU with PC and branch-target adders
// Ports: clock, reset (async, active-high); in_valid, alu_op_1/alu_op_0,
//        instruction_part, input_data_1 (A), input_data_2 (B), pc, offset (words)
//        -> out_valid, operation_code, output_data, output_zero, output_illegal,
//           output_pc_next, output_branch_target.
// Option ALU_EXEC_FLAGS_EN adds output_negative, output_carry, output_overflow.
module alu_exec_unit
    import alu_exec_pkg::*;
#(
    parameter int WIDTH  = 64,
    parameter int PC_INC = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             alu_op_1,
    input  logic             alu_op_0,
    input  logic [10:0]      instruction_part,
    input  logic [WIDTH-1:0] input_data_1,
    input  logic [WIDTH-1:0] input_data_2,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] offset,
    output logic             out_valid,
    output logic [3:0]       operation_code,
    output logic [WIDTH-1:0] output_data,
    output logic             output_zero,
    output logic             output_illegal,
    output logic [WIDTH-1:0] output_pc_next,
    output logic [WIDTH-1:0] output_branch_target
`ifdef ALU_EXEC_FLAGS_EN
    ,
    output logic             output_negative,
    output logic             output_carry,
    output logic             output_overflow
`endif
);

    localparam logic [WIDTH-1:0] PC_INC_W = WIDTH'(PC_INC);

    logic [3:0]       dec_code;
    logic             dec_illegal;
    logic [WIDTH-1:0] alu_result;

    alu_exec_decode u_decode (
        .alu_op_1         (alu_op_1),
        .alu_op_0         (alu_op_0),
        .instruction_part (instruction_part),
        .operation_code   (dec_code),
        .illegal          (dec_illegal)
    );

    always_comb begin
        alu_result = '0;
        case (dec_code)
            OP_AND:    alu_result = input_data_1 & input_data_2;
            OP_ORR:    alu_result = input_data_1 | input_data_2;
            OP_ADD:    alu_result = input_data_1 + input_data_2;
            OP_SUB:    alu_result = input_data_1 - input_data_2;
            OP_PASS_B: alu_result = input_data_2;
            OP_NOR:    alu_result = ~(input_data_1 | input_data_2);
            default:   alu_result = '0;
        endcase
    end

`ifdef ALU_EXEC_FLAGS_EN
    logic             is_sub;
    logic             is_arith;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   arith_ext;
    logic             carry_c;
    logic             overflow_c;

    // Subtract is formed as A + ~B + 1 so carry means "no borrow"
    always_comb begin
        is_sub     = (dec_code == OP_SUB);
        is_arith   = (dec_code == OP_ADD) || is_sub;
        b_eff      = is_sub ? ~input_data_2 : input_data_2;
        arith_ext  = {1'b0, input_data_1} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
        carry_c    = is_arith & arith_ext[WIDTH];
        overflow_c = is_arith & (input_data_1[WIDTH-1] == b_eff[WIDTH-1])
                              & (arith_ext[WIDTH-1] != input_data_1[WIDTH-1]);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            output_negative <= 1'b0;
            output_carry    <= 1'b0;
            output_overflow <= 1'b0;
        end else if (in_valid) begin
            output_negative <= alu_result[WIDTH-1];
            output_carry    <= carry_c;
            output_overflow <= overflow_c;
        end
    end
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            out_valid            <= 1'b0;
            operation_code       <= 4'b0000;
            output_data          <= '0;
            output_zero          <= 1'b0;
            output_illegal       <= 1'b0;
            output_pc_next       <= '0;
            output_branch_target <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                operation_code       <= dec_code;
                output_data          <= alu_result;
                output_zero          <= (alu_result == '0);
                output_illegal       <= dec_illegal;
                output_pc_next       <= pc + PC_INC_W;
                output_branch_target <= pc + (offset << 2);
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - scoreboard testbench for alu_exec_unit
module tb_alu_exec_unit;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        alu_op_1;
    logic        alu_op_0;
    logic [10:0] instruction_part;
    logic [63:0] input_data_1;
    logic [63:0] input_data_2;
    logic [63:0] pc;
    logic [63:0] offset;
    logic        out_valid;
    logic [3:0]  operation_code;
    logic [63:0] output_data;
    logic        output_zero;
    logic        output_illegal;
    logic [63:0] output_pc_next;
    logic [63:0] output_branch_target;

    alu_exec_unit #(.WIDTH(64), .PC_INC(4)) dut (
        .clock                (clock),
        .reset                (reset),
        .in_valid             (in_valid),
        .alu_op_1             (alu_op_1),
        .alu_op_0             (alu_op_0),
        .instruction_part     (instruction_part),
        .input_data_1         (input_data_1),
        .input_data_2         (input_data_2),
        .pc                   (pc),
        .offset               (offset),
        .out_valid            (out_valid),
        .operation_code       (operation_code),
        .output_data          (output_data),
        .output_zero          (output_zero),
        .output_illegal       (output_illegal),
        .output_pc_next       (output_pc_next),
        .output_branch_target (output_branch_target)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  code;
        logic [63:0] data;
        logic        zero;
        logic        ill;
        logic [63:0] pcn;
        logic [63:0] bt;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        last_exp;
    int          total = 0;
    int          bad = 0;
    logic [10:0] legal_ops[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: behaviour stated as mnemonic arithmetic, independent of encodings in the RTL
    function automatic exp_t predict(input logic [1:0] aop, input logic [10:0] ins,
                                     input logic [63:0] a, input logic [63:0] b,
                                     input logic [63:0] p, input logic [63:0] o);
        exp_t e;
        e.ill = 1'b0;
        if (aop == 2'd0) begin
            e.code = 4'd2;  e.data = a + b;
        end else if (aop == 2'd1) begin
            e.code = 4'd7;  e.data = b;
        end else if (ins == 11'b10001011000) begin
            e.code = 4'd2;  e.data = a + b;
        end else if (ins == 11'b11001011000) begin
            e.code = 4'd6;  e.data = a - b;
        end else if (ins == 11'b10001010000) begin
            e.code = 4'd0;  e.data = a & b;
        end else if (ins == 11'b10101010000) begin
            e.code = 4'd1;  e.data = a | b;
        end else begin
            e.code = 4'd15; e.data = 64'd0; e.ill = 1'b1;
        end
        e.zero = (e.data == 64'd0);
        e.pcn  = p + 64'd4;
        e.bt   = p + o * 64'd4;
        return e;
    endfunction

    task automatic issue(input bit v, input logic [1:0] aop, input logic [10:0] ins,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] p, input logic [63:0] o);
        @(posedge clock);
        #2;
        in_valid         = v;
        {alu_op_1, alu_op_0} = aop;
        instruction_part = ins;
        input_data_1     = a;
        input_data_2     = b;
        pc               = p;
        offset           = o;
        if (v) sb_q.push_back(predict(aop, ins, a, b, p, o));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, 64'(out_valid), 64'd0);
        chk({tag, "_code"}, 64'(operation_code), 64'd0);
        chk({tag, "_data"}, output_data, 64'd0);
        chk({tag, "_zero"}, 64'(output_zero), 64'd0);
        chk({tag, "_ill"}, 64'(output_illegal), 64'd0);
        chk({tag, "_pcn"}, output_pc_next, 64'd0);
        chk({tag, "_bt"}, output_branch_target, 64'd0);
    endtask

    // Monitor: pops one expectation per presented result, checks holds otherwise
    initial begin
        last_exp = '{code: 4'd0, data: 64'd0, zero: 1'b0, ill: 1'b0, pcn: 64'd0, bt: 64'd0};
        forever begin
            @(negedge clock);
            if (reset) begin
                last_exp = '{code: 4'd0, data: 64'd0, zero: 1'b0, ill: 1'b0, pcn: 64'd0, bt: 64'd0};
                chk("rst_valid", 64'(out_valid), 64'd0);
                chk("rst_data", output_data, 64'd0);
            end else if (out_valid) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_valid", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("code", 64'(operation_code), 64'(e.code));
                    chk("data", output_data, e.data);
                    chk("zero", 64'(output_zero), 64'(e.zero));
                    chk("illegal", 64'(output_illegal), 64'(e.ill));
                    chk("pc_next", output_pc_next, e.pcn);
                    chk("branch_target", output_branch_target, e.bt);
                    last_exp = e;
                end
            end else begin
                // At most the just-driven transaction may still be waiting
                if (sb_q.size() > 1) chk("missing_result", 64'(sb_q.size()), 64'd1);
                chk("hold_data", output_data, last_exp.data);
                chk("hold_zero", 64'(output_zero), 64'(last_exp.zero));
                chk("hold_code", 64'(operation_code), 64'(last_exp.code));
            end
        end
    end

    initial begin
        legal_ops[0] = 11'b10001011000;
        legal_ops[1] = 11'b11001011000;
        legal_ops[2] = 11'b10001010000;
        legal_ops[3] = 11'b10101010000;
        reset = 1'b0; in_valid = 1'b0; alu_op_1 = 1'b0; alu_op_0 = 1'b0;
        instruction_part = '0; input_data_1 = '0; input_data_2 = '0; pc = '0; offset = '0;
        #2 reset = 1'b1;
        #1 chk_all_zero("reset");
        @(posedge clock); @(posedge clock);
        #2 reset = 1'b0;

        // Directed cases
        issue(1, 2'b00, 11'd0, 64'd10, 64'd32, 64'h100, 64'd3);
        issue(1, 2'b10, 11'b11001011000, 64'd5, 64'd5, 64'h200, 64'd0);
        issue(1, 2'b01, 11'd0, 64'd7, 64'd0, 64'h10, 64'd1);
        issue(1, 2'b01, 11'd0, 64'd7, 64'd9, 64'h10, 64'd1);
        issue(0, 2'b00, 11'd0, 64'd1, 64'd1, 64'h0, 64'd0);
        issue(1, 2'b10, 11'b10101010000, 64'hF0, 64'h0F, 64'h0, 64'd0);
        issue(1, 2'b11, 11'b11111111111, 64'hF0, 64'h0F, 64'h0, 64'd0);
        issue(1, 2'b00, 11'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC);
        issue(1, 2'b10, 11'b10001010000, 64'hFF00, 64'h0FF0, 64'h40, 64'd2);
        issue(0, 2'b00, 11'd0, 64'd3, 64'd3, 64'h0, 64'd0);
        issue(0, 2'b00, 11'd0, 64'd3, 64'd3, 64'h0, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  aop;
            logic [10:0] ins;
            logic [63:0] a, b;
            aop = 2'($urandom_range(0, 3));
            ins = ($urandom_range(0, 4) == 0) ? 11'($urandom) : legal_ops[$urandom_range(0, 3)];
            a   = {$urandom, $urandom};
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = 64'($urandom_range(0, 3));
                default: b = {$urandom, $urandom};
            endcase
            issue($urandom_range(0, 3) != 0, aop, ins, a, b, {$urandom, $urandom}, {$urandom, $urandom});

            if (i == 150) begin
                // Reset lands while a transaction is being driven
                issue(1, 2'b00, 11'd0, 64'd1, 64'd2, 64'h4, 64'd1);
                #1 reset = 1'b1;
                #1 chk_all_zero("midreset");
                sb_q.delete();
                @(posedge clock);
                #2 reset = 1'b0; in_valid = 1'b0;
                @(posedge clock);
                #4 chk("post_reset_valid", 64'(out_valid), 64'd0);
            end
        end

        issue(0, 2'b00, 11'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        issue(0, 2'b00, 11'd0, 64'd0, 64'd0, 64'd0, 64'd0);
        @(posedge clock);
        #6 chk("drain_empty", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
